// File: rtl/pcpi_result_serializer_pkg.sv
// Shared types, defaults and the parity helper for the PCPI result serializer.
// RESULT_PARITY_EN (see top) decides whether nib_xor() is used.
package pcpi_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int NIB_W_DEF    = 4;
    localparam int DATA_W_DEF   = 32;
    localparam int NUM_NIB_DATA = DATA_W_DEF / NIB_W_DEF;

    // XOR of the lowest n nibbles of w; wide enough for any word up to 64 bits.
    function automatic logic [NIB_W_DEF-1:0] nib_xor(input logic [63:0] w, input int n);
        logic [NIB_W_DEF-1:0] acc;
        acc = '0;
        for (int i = 0; i < 64 / NIB_W_DEF; i++) begin
            if (i < n) acc ^= w[i*NIB_W_DEF +: NIB_W_DEF];
        end
        return acc;
    endfunction

endpackage

// File: rtl/pcpi_result_serializer_if.sv
// Coprocessor-result input and host nibble bus of the result serializer.
interface pcpi_result_serializer_if #(
    parameter int DATA_W = 32,
    parameter int NIB_W  = 4
);
    logic              pcpi_ready;
    logic              pcpi_wr;
    logic [DATA_W-1:0] pcpi_rd;
    logic              out_ack;
    logic [NIB_W-1:0]  out_nib;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              overflow;

    // slave: the serializer itself; master: coprocessor plus host side
    modport slave (
        input  pcpi_ready, pcpi_wr, pcpi_rd, out_ack,
        output out_nib, out_valid, out_last, busy, overflow
    );
    modport master (
        output pcpi_ready, pcpi_wr, pcpi_rd, out_ack,
        input  out_nib, out_valid, out_last, busy, overflow
    );
endinterface

// File: rtl/pcpi_result_serializer_nibble_ack_edge.sv
// Rising-edge detector on the (already synchronized) host acknowledge level.
module nibble_ack_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ack,
    output logic ack_rise
);
    logic ack_q;

    always_ff @(posedge clk) begin
        if (!rst_n) ack_q <= 1'b0;
        else        ack_q <= ack;
    end

    assign ack_rise = ack & ~ack_q;
endmodule

// File: rtl/pcpi_result_serializer.sv
// Serializes each captured pcpi_rd result to the host one nibble per ack, LSB nibble first.
// Optional RESULT_PARITY_EN appends an XOR parity nibble to every word.
//
// state | meaning
// IDLE  | nothing to send, out_valid low
// SEND  | shreg low nibble is on out_nib, waiting for ack_rise
module pcpi_result_serializer
    import pcpi_ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NIB_W  = NIB_W_DEF
) (
    input logic                    clk,
    input logic                    rst_n,
    pcpi_result_serializer_if.slave bus
);
    localparam int DATA_NIB = DATA_W / NIB_W;
`ifdef RESULT_PARITY_EN
    localparam int NUM_NIB  = DATA_NIB + 1;
`else
    localparam int NUM_NIB  = DATA_NIB;
`endif
    localparam int SHREG_W  = NUM_NIB * NIB_W;
    localparam int CNT_W    = $clog2(NUM_NIB);

    state_t             state, state_nxt;
    logic [SHREG_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]  pend, pend_nxt;
    logic               pend_v, pend_v_nxt;
    logic               overflow, overflow_nxt;
    logic               ack_rise, cap, at_last;

    // Parity is folded into the shift register at load time so the shift path stays uniform.
    function automatic logic [SHREG_W-1:0] load(input logic [DATA_W-1:0] w);
`ifdef RESULT_PARITY_EN
        return {NIB_W'(nib_xor(64'(w), DATA_NIB)), w};
`else
        return SHREG_W'(w);
`endif
    endfunction

    nibble_ack_edge u_ack_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .ack      (bus.out_ack),
        .ack_rise (ack_rise)
    );

    assign cap     = bus.pcpi_ready & bus.pcpi_wr;
    assign at_last = (cnt == CNT_W'(NUM_NIB - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            pend     <= '0;
            pend_v   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            cnt      <= cnt_nxt;
            pend     <= pend_nxt;
            pend_v   <= pend_v_nxt;
            overflow <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        cnt_nxt      = cnt;
        pend_nxt     = pend;
        pend_v_nxt   = pend_v;
        overflow_nxt = overflow;
        case (state)
            IDLE: begin
                if (cap) begin
                    shreg_nxt = load(bus.pcpi_rd);
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (ack_rise && at_last) begin
                    cnt_nxt = '0;
                    if (pend_v) begin
                        // pend drains into shreg; a simultaneous capture refills pend without loss
                        shreg_nxt = load(pend);
                        if (cap) pend_nxt = bus.pcpi_rd;
                        else     pend_v_nxt = 1'b0;
                    end else if (cap) begin
                        shreg_nxt = load(bus.pcpi_rd);
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    if (ack_rise) begin
                        shreg_nxt = shreg >> NIB_W;
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                    if (cap) begin
                        if (!pend_v) begin
                            pend_nxt   = bus.pcpi_rd;
                            pend_v_nxt = 1'b1;
                        end else begin
                            overflow_nxt = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (state == SEND);
        bus.out_nib   = (state == SEND) ? shreg[NIB_W-1:0] : '0;
        bus.out_last  = (state == SEND) && at_last;
        bus.busy      = (state == SEND) || pend_v;
        bus.overflow  = overflow;
    end
endmodule
